// File: rtl/npc_unit.sv
// ============================================================================
// Module   : npc_unit
// Brief    : Next-PC generator for the single-cycle MIPS datapath. Handles
//            branch/jump/jr target selection, jal link address, optional
//            branch-delay-slot sequencing (NPC_DELAY_SLOT_EN) and a sticky
//            fetch-fault halt for misaligned or out-of-range targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int unsigned IM_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_take,
    input  logic [15:0] br_offset,
    input  logic        j_valid,
    input  logic [25:0] j_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic [31:0] next,
    output logic [31:0] link_addr,
    output logic        in_delay,
    output logic        fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DELAY  = 2'd1,
        HALT   = 2'd2
    } state_t;

    // One bit wider so a range ending exactly at 2^32 still compares correctly.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    function automatic logic is_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= IM_BASE) && ({1'b0, addr} < IM_LIMIT);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] w_seq, w_br, w_jmp, w_target;
    logic        w_req;

    assign w_seq = pc + 32'd4;
    assign w_br  = w_seq + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign w_jmp = {w_seq[31:28], j_index, 2'b00};
    assign w_req = jr_valid | j_valid | br_take;

    always_comb begin
        w_target = w_br;
        if (jr_valid)     w_target = jr_target;
        else if (j_valid) w_target = w_jmp;
    end

`ifdef NPC_DELAY_SLOT_EN
    logic [31:0] pending_q, pending_d;
    assign link_addr = pc + 32'd8;
    assign in_delay  = (state_q == DELAY);
`else
    assign link_addr = pc + 32'd4;
    assign in_delay  = 1'b0;
`endif

    assign fault      = (state_q == HALT);
    assign fault_addr = fault_addr_q;

    always_comb begin
        next         = w_seq;
        state_d      = state_q;
        fault_addr_d = fault_addr_q;
`ifdef NPC_DELAY_SLOT_EN
        pending_d    = pending_q;
`endif
        if (reset) begin
            next = RESET_ADDR;
        end else if (state_q == HALT || stall) begin
            next = pc;
`ifdef NPC_DELAY_SLOT_EN
        end else if (state_q == DELAY) begin
            // Delay-slot instruction's own control requests are dropped here.
            next    = pending_q;
            state_d = NORMAL;
`endif
        end else if (w_req) begin
            if (!is_legal(w_target)) begin
                next         = pc;
                fault_addr_d = w_target;
                state_d      = HALT;
`ifdef NPC_DELAY_SLOT_EN
            end else if (!is_legal(w_seq)) begin
                next         = pc;
                fault_addr_d = w_seq;
                state_d      = HALT;
            end else begin
                next      = w_seq;
                pending_d = w_target;
                state_d   = DELAY;
            end
`else
            end else begin
                next = w_target;
            end
`endif
        end else if (!is_legal(w_seq)) begin
            next         = pc;
            fault_addr_d = w_seq;
            state_d      = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NORMAL;
            fault_addr_q <= 32'd0;
`ifdef NPC_DELAY_SLOT_EN
            pending_q    <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            fault_addr_q <= fault_addr_d;
`ifdef NPC_DELAY_SLOT_EN
            pending_q    <= pending_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_npc_unit.sv
// ============================================================================
// Module   : tb_npc_unit
// Brief    : Directed self-checking bench for npc_unit; expected values are
//            queued when stimulus is applied and compared at the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_npc_unit;

`ifdef NPC_DELAY_SLOT_EN
    localparam logic [31:0] LK = 32'd8;
`else
    localparam logic [31:0] LK = 32'd4;
`endif

    typedef struct {
        string       tag;
        logic [31:0] nxt;
        logic [31:0] lnk;
        logic        dly;
        logic        flt;
        logic [31:0] fa;
    } exp_t;

    logic        clk = 1'b0;
    logic        r_reset, r_stall, r_br, r_jv, r_jrv;
    logic [31:0] r_pc, r_jt;
    logic [15:0] r_off;
    logic [25:0] r_ji;
    logic [31:0] w_next, w_link, w_fa;
    logic        w_dly, w_flt;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    npc_unit dut (
        .clk        (clk),
        .reset      (r_reset),
        .pc         (r_pc),
        .stall      (r_stall),
        .br_take    (r_br),
        .br_offset  (r_off),
        .j_valid    (r_jv),
        .j_index    (r_ji),
        .jr_valid   (r_jrv),
        .jr_target  (r_jt),
        .next       (w_next),
        .link_addr  (w_link),
        .in_delay   (w_dly),
        .fault      (w_flt),
        .fault_addr (w_fa)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s.%s: got %h want %h", tag, fld, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check at negedge.
    task automatic go(input string tag, input logic [31:0] p, input logic st, input logic br,
                      input logic [15:0] off, input logic jv, input logic [25:0] ji,
                      input logic jrv, input logic [31:0] jt,
                      input logic [31:0] nxt, input logic dly, input logic flt, input logic [31:0] fa);
        exp_t e;
        r_pc = p; r_stall = st; r_br = br; r_off = off;
        r_jv = jv; r_ji = ji; r_jrv = jrv; r_jt = jt;
        q.push_back('{tag: tag, nxt: nxt, lnk: p + LK, dly: dly, flt: flt, fa: fa});
        @(negedge clk);
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.queue: got empty want entry", tag);
        end else begin
            e = q.pop_front();
            chk(e.tag, "next", w_next, e.nxt);
            chk(e.tag, "link", w_link, e.lnk);
            chk(e.tag, "in_delay", {31'd0, w_dly}, {31'd0, e.dly});
            chk(e.tag, "fault", {31'd0, w_flt}, {31'd0, e.flt});
            chk(e.tag, "fault_addr", w_fa, e.fa);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [31:0] p, input logic [31:0] nxt,
                        input logic dly, input logic flt, input logic [31:0] fa);
        go(tag, p, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, nxt, dly, flt, fa);
    endtask

    initial begin
        r_reset = 1'b1;
        r_pc = 32'h0; r_stall = 1'b0; r_br = 1'b0; r_off = 16'h0;
        r_jv = 1'b0; r_ji = 26'h0; r_jrv = 1'b0; r_jt = 32'h0;
        @(posedge clk);
        #1;
        idle("reset", 32'h0, 32'h3000, 1'b0, 1'b0, 32'h0);
        r_reset = 1'b0;

        idle("seq0", 32'h3000, 32'h3004, 1'b0, 1'b0, 32'h0);
        idle("seq1", 32'h3004, 32'h3008, 1'b0, 1'b0, 32'h0);
        idle("seq2", 32'h3008, 32'h300C, 1'b0, 1'b0, 32'h0);

`ifdef NPC_DELAY_SLOT_EN
        go("br", 32'h3010, 1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0, 32'h3014, 1'b0, 1'b0, 32'h0);
        idle("br_tgt", 32'h3014, 32'h3004, 1'b1, 1'b0, 32'h0);
        go("br2", 32'h3010, 1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0, 32'h3014, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            go("stall_dly", 32'h3014, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h3014, 1'b1, 1'b0, 32'h0);
        go("slot_br", 32'h3014, 1'b0, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0, 32'h3004, 1'b1, 1'b0, 32'h0);
        idle("after_slot", 32'h3004, 32'h3008, 1'b0, 1'b0, 32'h0);
        go("jr_over_j", 32'h3020, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0000C80, 1'b1, 32'h3100, 32'h3024, 1'b0, 1'b0, 32'h0);
        idle("jr_tgt", 32'h3024, 32'h3100, 1'b1, 1'b0, 32'h0);
        go("j", 32'h3100, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0000C80, 1'b0, 32'h0, 32'h3104, 1'b0, 1'b0, 32'h0);
        idle("j_tgt", 32'h3104, 32'h3200, 1'b1, 1'b0, 32'h0);
        go("j_over_br", 32'h3200, 1'b0, 1'b1, 16'h0100, 1'b1, 26'h0000C90, 1'b0, 32'h0, 32'h3204, 1'b0, 1'b0, 32'h0);
        idle("j_over_br_tgt", 32'h3204, 32'h3240, 1'b1, 1'b0, 32'h0);
`else
        go("br", 32'h3010, 1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0, 32'h3004, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            go("stall", 32'h3004, 1'b1, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0, 32'h3004, 1'b0, 1'b0, 32'h0);
        idle("after_stall", 32'h3004, 32'h3008, 1'b0, 1'b0, 32'h0);
        go("jr_over_j", 32'h3020, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0000C80, 1'b1, 32'h3100, 32'h3100, 1'b0, 1'b0, 32'h0);
        go("j", 32'h3100, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0000C80, 1'b0, 32'h0, 32'h3200, 1'b0, 1'b0, 32'h0);
        go("j_over_br", 32'h3200, 1'b0, 1'b1, 16'h0100, 1'b1, 26'h0000C90, 1'b0, 32'h0, 32'h3240, 1'b0, 1'b0, 32'h0);
`endif

        go("jr_misalign", 32'h3240, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h3102, 32'h3240, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++)
            go("halt", 32'h3240, 1'($urandom_range(0, 1)), 1'b1, 16'h0004, 1'b1, 26'h0000C80, 1'b1, 32'h3100,
               32'h3240, 1'b0, 1'b1, 32'h3102);
        r_reset = 1'b1;
        go("rst_hold", 32'h3240, 1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0, 32'h3000, 1'b0, 1'b1, 32'h3102);
        idle("rst_clear", 32'h3240, 32'h3000, 1'b0, 1'b0, 32'h0);
        r_reset = 1'b0;

        idle("lim_last", 32'h6FF8, 32'h6FFC, 1'b0, 1'b0, 32'h0);
        idle("lim_over", 32'h6FFC, 32'h6FFC, 1'b0, 1'b0, 32'h0);
        idle("lim_halt", 32'h6FFC, 32'h6FFC, 1'b0, 1'b1, 32'h7000);
        r_reset = 1'b1;
        idle("rst2_hold", 32'h6FFC, 32'h3000, 1'b0, 1'b1, 32'h7000);
        idle("rst2_clear", 32'h6FFC, 32'h3000, 1'b0, 1'b0, 32'h0);
        r_reset = 1'b0;

        go("jr_below", 32'h3000, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h2FFC, 32'h3000, 1'b0, 1'b0, 32'h0);
        idle("below_halt", 32'h3000, 32'h3000, 1'b0, 1'b1, 32'h2FFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
